// File: rtl/piso_pkg.sv
// Shared helpers for the piso width converter.
`timescale 1ns/1ps
package piso_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int c_log_2(input int value);
    int unsigned r;
    r = 0;
    while ((1 << r) < value) r++;
    return int'(r);
  endfunction

endpackage

// File: rtl/piso.sv
// Parallel-in/serial-out width converter: one wide word per handshake, emitted
// LSB chunk first, with a one-word holding buffer for bubble-free streaming.
`timescale 1ns/1ps
module piso
  import piso_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  input  logic [DATA_IN_WIDTH-1:0]  s_data,
  output logic                      s_ready,
  output logic                      m_valid,
  output logic [DATA_OUT_WIDTH-1:0] m_data,
  output logic                      m_last,
  input  logic                      m_ready
);

  localparam int NUM_SHIFTS = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int CW         = c_log_2(NUM_SHIFTS) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_SHIFTS - 1);

  if (DATA_IN_WIDTH % DATA_OUT_WIDTH != 0) begin : g_width_check
    $error("piso: DATA_IN_WIDTH must be a multiple of DATA_OUT_WIDTH");
  end

  logic [DATA_IN_WIDTH-1:0] shift;
  logic                     shift_valid;
  logic [CW-1:0]            count;
  logic [DATA_IN_WIDTH-1:0] hold;
  logic                     hold_valid;

  logic beat;
  logic last_beat;
  logic accept;
  logic fill;

  always_comb begin
    beat      = shift_valid && m_ready;
    last_beat = beat && (count == LAST_COUNT);
    accept    = s_valid && !hold_valid;
    fill      = !shift_valid || (last_beat && !hold_valid);
  end

  assign s_ready = !hold_valid;
  assign m_valid = shift_valid;
  assign m_data  = shift[DATA_OUT_WIDTH-1:0];
  assign m_last  = shift_valid && (count == LAST_COUNT);

  // Shift-register side: a pending held word always takes priority over new
  // input; s_ready is low in that case so the two can never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift       <= '0;
      shift_valid <= 1'b0;
      count       <= '0;
    end else if (last_beat && hold_valid) begin
      shift       <= hold;
      shift_valid <= 1'b1;
      count       <= '0;
    end else if (accept && fill) begin
      shift       <= s_data;
      shift_valid <= 1'b1;
      count       <= '0;
    end else if (last_beat) begin
      shift_valid <= 1'b0;
      count       <= '0;
    end else if (beat) begin
      shift <= shift >> DATA_OUT_WIDTH;
      count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (last_beat && hold_valid) begin
      hold_valid <= 1'b0;
    end else if (accept && !fill) begin
      hold       <= s_data;
      hold_valid <= 1'b1;
    end
  end

endmodule
